// File: rtl/alu_share_arbiter_if.sv
// Handshake bundle between two requesters and the shared ALU arbiter.
// Requesters hold the master side; the arbiter holds the slave side.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 17
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic [3:0]         req_op;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [WIDTH-1:0]   rsp_out;
  logic [3:0]         rsp_flags;
  logic [3:0]         last_flags;
  logic               busy;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_out, rsp_flags, last_flags, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_out, rsp_flags, last_flags, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one add/sub/xor/not ALU (NZCV flags) between
// two valid/ready requesters; IDLE -> EXEC -> RESP per operation.
module alu_share_arbiter #(
  parameter int WIDTH = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_last_grant;
  logic             r_grant;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic [1:0]       r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_out;
  logic [3:0]       r_rsp_flags;
  logic [3:0]       r_last_flags;
  logic             r_busy;

  logic             w_grant;
  logic [1:0]       w_req_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_a_sel;
  logic [WIDTH-1:0] w_b_sel;
  logic [1:0]       w_op_sel;
  logic [WIDTH+3:0] w_alu;

  // Result packed as {N, Z, C, V, result}; C on subtract means "no borrow".
  function automatic logic [WIDTH+3:0] alu_eval(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [1:0]       op
  );
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;
    sum = {(WIDTH+1){1'b0}};
    res = {WIDTH{1'b0}};
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      2'b00: begin
        sum = {1'b0, a} + {1'b0, b};
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      2'b01: begin
        sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      2'b10: res = a ^ b;
      2'b11: res = ~a;
      default: res = {WIDTH{1'b0}};
    endcase
    return {res[WIDTH-1], (res == {WIDTH{1'b0}}), c, v, res};
  endfunction

  // Pick the requester to offer ready to; ties go to the one not served last.
  always_comb begin
    w_grant     = 1'b0;
    w_req_ready = 2'b00;
    case (bus.req_valid)
      2'b01:   w_grant = 1'b0;
      2'b10:   w_grant = 1'b1;
      2'b11:   w_grant = ~r_last_grant;
      default: w_grant = 1'b0;
    endcase
    if (rst_n && (r_state == S_IDLE) && (bus.req_valid != 2'b00)) begin
      w_req_ready = w_grant ? 2'b10 : 2'b01;
    end else begin
      w_req_ready = 2'b00;
    end
  end

  assign w_accept = |w_req_ready;
  assign w_a_sel  = w_grant ? bus.req_a[WIDTH +: WIDTH] : bus.req_a[0 +: WIDTH];
  assign w_b_sel  = w_grant ? bus.req_b[WIDTH +: WIDTH] : bus.req_b[0 +: WIDTH];
  assign w_op_sel = w_grant ? bus.req_op[3:2] : bus.req_op[1:0];
  assign w_alu    = alu_eval(r_a, r_b, r_op);

  // Operation sequencer with all outputs and operands registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_a          <= {WIDTH{1'b0}};
      r_b          <= {WIDTH{1'b0}};
      r_op         <= 2'b00;
      r_rsp_valid  <= 2'b00;
      r_rsp_out    <= {WIDTH{1'b0}};
      r_rsp_flags  <= 4'b0000;
      r_last_flags <= 4'b0000;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= w_a_sel;
            r_b     <= w_b_sel;
            r_op    <= w_op_sel;
            r_grant <= w_grant;
            r_busy  <= 1'b1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_flags <= w_alu[WIDTH+3:WIDTH];
          r_rsp_out   <= w_alu[WIDTH-1:0];
          r_rsp_valid <= r_grant ? 2'b10 : 2'b01;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          // Only the granted requester's rsp_ready can retire the response.
          if (bus.rsp_ready[r_grant]) begin
            r_last_flags <= r_rsp_flags;
            r_last_grant <= r_grant;
            r_rsp_valid  <= 2'b00;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 2'b00;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_out    = r_rsp_out;
  assign bus.rsp_flags  = r_rsp_flags;
  assign bus.last_flags = r_last_flags;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed plus random traffic for alu_share_arbiter, checked every cycle
// against a transaction-level reference model.
module tb_alu_share_arbiter;
  localparam int W   = 17;
  localparam int MOD = 1 << W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.WIDTH(W)) bus ();
  alu_share_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Bench-side stimulus copies
  logic [1:0]   v;
  logic [1:0]   rr;
  logic [W-1:0] a [2];
  logic [W-1:0] b [2];
  logic [1:0]   op [2];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one pending transaction with an age in cycles
  bit           m_pend;
  int           m_age;
  bit           m_g;
  bit           m_lg;
  logic [W-1:0] m_res, m_out;
  logic [3:0]   m_fl, m_rflags, m_lflags;
  logic [1:0]   m_acc;

  function automatic logic [W+3:0] ref_alu(input int unsigned x, input int unsigned y, input int o);
    int unsigned r;
    int          sx, sy, sr;
    bit          c, ov;
    sx = (x >= 65536) ? int'(x) - 131072 : int'(x);
    sy = (y >= 65536) ? int'(y) - 131072 : int'(y);
    c = 1'b0; ov = 1'b0; r = 0;
    case (o)
      0: begin r = (x + y) % MOD; c = (x + y) >= MOD; sr = sx + sy; ov = (sr > 65535) || (sr < -65536); end
      1: begin r = (x + MOD - y) % MOD; c = (x >= y); sr = sx - sy; ov = (sr > 65535) || (sr < -65536); end
      2: r = x ^ y;
      default: r = (~x) & (MOD - 1);
    endcase
    return {(r >= 65536), (r == 0), c, ov, r[W-1:0]};
  endfunction

  function automatic bit pick(input logic [1:0] vv, input bit lg);
    if (vv == 2'b11) return !lg;
    return vv[1];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.req_valid = v;
    bus.rsp_ready = rr;
    bus.req_a     = {a[1], a[0]};
    bus.req_b     = {b[1], b[0]};
    bus.req_op    = {op[1], op[0]};
  endtask

  task automatic model_reset();
    m_pend = 0; m_age = 0; m_g = 0; m_lg = 1;
    m_res = '0; m_out = '0; m_fl = '0; m_rflags = '0; m_lflags = '0; m_acc = '0;
  endtask

  task automatic check_cycle();
    logic [1:0] er;
    er = 2'b00;
    if (!m_pend && v != 2'b00) er = pick(v, m_lg) ? 2'b10 : 2'b01;
    chk("req_ready", bus.req_ready, er);
    chk("rsp_valid", bus.rsp_valid, (m_pend && m_age >= 2) ? (m_g ? 2'b10 : 2'b01) : 2'b00);
    chk("rsp_out", bus.rsp_out, m_out);
    chk("rsp_flags", bus.rsp_flags, m_rflags);
    chk("last_flags", bus.last_flags, m_lflags);
    chk("busy", bus.busy, m_pend);
  endtask

  task automatic model_edge();
    bit g;
    m_acc = 2'b00;
    if (!m_pend) begin
      if (v != 2'b00) begin
        g = pick(v, m_lg);
        m_acc = g ? 2'b10 : 2'b01;
        {m_fl, m_res} = ref_alu(a[g], b[g], op[g]);
        m_pend = 1; m_g = g; m_age = 1;
      end
    end else if (m_age == 1) begin
      m_out = m_res; m_rflags = m_fl; m_age = 2;
    end else if (rr[m_g]) begin
      m_lflags = m_rflags; m_lg = m_g; m_pend = 0;
    end
  endtask

  task automatic tick();
    drive();
    #1;
    check_cycle();
    model_edge();
    @(negedge clk);
  endtask

  task automatic expect_resp(input string tag, input bit g, input logic [W-1:0] o, input logic [3:0] f);
    chk({tag, "_valid"}, bus.rsp_valid, g ? 2'b10 : 2'b01);
    chk({tag, "_out"}, bus.rsp_out, o);
    chk({tag, "_flags"}, bus.rsp_flags, f);
  endtask

  task automatic apply_reset();
    v = 2'b00;
    drive();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", bus.req_ready, 2'b00);
    chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
    chk("rst_rsp_out", bus.rsp_out, 17'h00000);
    chk("rst_rsp_flags", bus.rsp_flags, 4'b0000);
    chk("rst_last_flags", bus.last_flags, 4'b0000);
    chk("rst_busy", bus.busy, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 17'h00000;
      1: return 17'h10000;
      2: return 17'h1FFFF;
      3: return 17'h0FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    rst_n = 1'b1;
    v = 2'b00; rr = 2'b00;
    for (int i = 0; i < 2; i++) begin a[i] = '0; b[i] = '0; op[i] = 2'b00; end
    apply_reset();
    tick();

    // Single subtract from requester 0
    v = 2'b01; a[0] = 17'd5; b[0] = 17'd2; op[0] = 2'b01; rr = 2'b11;
    tick();
    v = 2'b00;
    tick();
    expect_resp("t1", 1'b0, 17'd3, 4'b0010);
    tick();
    chk("t1_last", bus.last_flags, 4'b0010);

    // Simultaneous requests right after reset: requester 0 first
    apply_reset();
    v = 2'b11; rr = 2'b11;
    a[0] = 17'd2; b[0] = 17'd2; op[0] = 2'b01;
    a[1] = 17'd2; b[1] = 17'd5; op[1] = 2'b01;
    tick();
    v = 2'b10;
    tick();
    expect_resp("t2a", 1'b0, 17'd0, 4'b0110);
    tick();
    tick();
    v = 2'b00;
    tick();
    expect_resp("t2b", 1'b1, 17'h1FFFD, 4'b1000);
    tick();

    // Both held valid: grants alternate
    v = 2'b11;
    a[0] = 17'd5; b[0] = 17'd2; op[0] = 2'b10;
    a[1] = 17'd2; b[1] = 17'd5; op[1] = 2'b10;
    for (int k = 0; k < 4; k++) begin
      tick();
      tick();
      expect_resp("t3", k[0], 17'd7, 4'b0000);
      tick();
    end
    v = 2'b00;

    // Stalled response blocks the other requester
    v = 2'b10; a[1] = 17'h00002; b[1] = 17'd0; op[1] = 2'b11; rr = 2'b00;
    tick();
    v = 2'b01; a[0] = 17'd1; b[0] = 17'd1; op[0] = 2'b00;
    tick();
    for (int k = 0; k < 5; k++) begin
      expect_resp("t4", 1'b1, 17'h1FFFD, 4'b1000);
      tick();
    end
    rr = 2'b10;
    tick();
    rr = 2'b01;
    tick();
    v = 2'b00;
    tick();
    expect_resp("t4b", 1'b0, 17'd2, 4'b0000);
    tick();

    // Reset during a pending response discards it
    v = 2'b01; a[0] = 17'd3; b[0] = 17'd4; op[0] = 2'b00; rr = 2'b00;
    tick();
    v = 2'b00;
    tick();
    expect_resp("t5a", 1'b0, 17'd7, 4'b0000);
    apply_reset();
    rr = 2'b11;
    for (int k = 0; k < 4; k++) tick();
    v = 2'b01; a[0] = 17'd10; b[0] = 17'd3; op[0] = 2'b01;
    tick();
    v = 2'b00;
    tick();
    expect_resp("t5b", 1'b0, 17'd7, 4'b0010);
    tick();

    // Random traffic; unaccepted requests keep their operands
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (v[i] && !m_acc[i]) begin
          if ($urandom_range(0, 7) == 0) v[i] = 1'b0;
        end else begin
          v[i]  = ($urandom_range(0, 2) != 0);
          a[i]  = rnd_operand();
          b[i]  = rnd_operand();
          op[i] = 2'($urandom_range(0, 3));
        end
      end
      rr = 2'($urandom_range(0, 3));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
